// File: rtl/bayer_window_7x7_pkg.sv
// Shared constants and the window slicing helper for the 7x7 Bayer window stage.
// Consumers use win_off() to locate Drc inside the flattened window bus.
package bayer_window_7x7_pkg;

   localparam int DATA_W_DEF = 10;
   localparam int WIN        = 7;

   // Bit offset of Drc (r,c in 1..WIN) inside a flattened WIN*WIN*data_w bus.
   function automatic int win_off(input int r, input int c, input int data_w);
      return ((r - 1) * WIN + (c - 1)) * data_w;
   endfunction

endpackage

// File: rtl/bayer_window_7x7_if.sv
// Pixel stream in, 7x7 window out; the producer drives the master side.
interface bayer_window_7x7_if #(
   parameter int DATA_W = bayer_window_7x7_pkg::DATA_W_DEF,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
);
   import bayer_window_7x7_pkg::*;

   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);

   logic [DATA_W-1:0]         in_pixel;
   logic                      in_valid;
   logic                      in_sof;
   logic [WIN*WIN*DATA_W-1:0] win;
   logic                      win_valid;
   logic [RW-1:0]             center_row;
   logic [CW-1:0]             center_col;

   modport master (
      output in_pixel, in_valid, in_sof,
      input  win, win_valid, center_row, center_col
   );

   modport slave (
      input  in_pixel, in_valid, in_sof,
      output win, win_valid, center_row, center_col
   );

endinterface

// File: rtl/bayer_line_buffer.sv
// One image line of storage; read returns the old word while the same address is written.
module bayer_line_buffer #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 640
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/bayer_window_7x7.sv
// Raster Bayer stream to registered 7x7 neighbourhood, one cycle latency, no backpressure.
// Only fully interior windows raise win_valid; centre coordinates track D44.
module bayer_window_7x7
   import bayer_window_7x7_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input logic              clk,
   input logic              rst_n,
   bayer_window_7x7_if.slave bus
);

   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);

   logic [RW-1:0]             row, pos_row, center_row_q;
   logic [CW-1:0]             col, pos_col, center_col_q;
   logic [DATA_W-1:0]         lb_rd [WIN-1];
   logic [DATA_W-1:0]         lb_wd [WIN-1];
   logic [DATA_W-1:0]         col_vec [WIN];
   logic [WIN*WIN*DATA_W-1:0] win_q, win_nxt;
   logic                      win_valid_q;

   // Start of frame forces this pixel to (0,0) whatever the counters say.
   assign pos_row = bus.in_sof ? '0 : row;
   assign pos_col = bus.in_sof ? '0 : col;

   for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
      if (k == 0) begin : g_head
         assign lb_wd[k] = bus.in_pixel;
      end else begin : g_chain
         assign lb_wd[k] = lb_rd[k-1];
      end
      bayer_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb (
         .clk   (clk),
         .en    (bus.in_valid),
         .addr  (pos_col),
         .wdata (lb_wd[k]),
         .rdata (lb_rd[k])
      );
   end

   // Bottom row is the live pixel; lb_rd[k] holds the pixel k+1 lines up.
   always_comb begin
      col_vec[WIN-1] = bus.in_pixel;
      for (int r = 0; r < WIN - 1; r++) begin
         col_vec[r] = lb_rd[WIN-2-r];
      end
   end

   always_comb begin
      win_nxt = win_q;
      for (int r = 1; r <= WIN; r++) begin
         for (int c = 1; c < WIN; c++) begin
            win_nxt[win_off(r, c, DATA_W) +: DATA_W] = win_q[win_off(r, c + 1, DATA_W) +: DATA_W];
         end
         win_nxt[win_off(r, WIN, DATA_W) +: DATA_W] = col_vec[r-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row          <= '0;
         col          <= '0;
         win_q        <= '0;
         win_valid_q  <= 1'b0;
         center_row_q <= '0;
         center_col_q <= '0;
      end else begin
         win_valid_q <= bus.in_valid && (pos_row >= RW'(WIN - 1)) && (pos_col >= CW'(WIN - 1));
         if (bus.in_valid) begin
            win_q        <= win_nxt;
            center_row_q <= pos_row - RW'(WIN / 2);
            center_col_q <= pos_col - CW'(WIN / 2);
            if (pos_col == CW'(IMG_W - 1)) begin
               col <= '0;
               row <= (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + RW'(1);
            end else begin
               col <= pos_col + CW'(1);
               row <= pos_row;
            end
         end
      end
   end

   assign bus.win        = win_q;
   assign bus.win_valid  = win_valid_q;
   assign bus.center_row = center_row_q;
   assign bus.center_col = center_col_q;

endmodule

// File: tb/tb_bayer_window_7x7.sv
// Scoreboard bench for bayer_window_7x7 on an 8x8 image with pixel = row*16+col (+frame salt).
module tb_bayer_window_7x7;
   import bayer_window_7x7_pkg::*;

   localparam int DW = 10;
   localparam int IW = 8;
   localparam int IH = 8;
   localparam int WB = WIN * WIN * DW;

   typedef struct packed {
      logic [WB-1:0] w;
      logic [2:0]    cr;
      logic [2:0]    cc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bayer_window_7x7_if #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) bus ();

   bayer_window_7x7 #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int            checks = 0;
   int            failures = 0;
   int            nvalid = 0;
   int            mr = 0;
   int            mc = 0;
   bit            exp_vld = 1'b0;
   bit            held = 1'b0;
   logic [WB-1:0] last_win = '0;
   logic [DW-1:0] img [IH][IW];
   exp_t          q[$];
   exp_t          mon_e;

   task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic spot(input string tag, input int r, input int c, input logic [DW-1:0] exp);
      check(tag, WB'(bus.win[win_off(r, c, DW) +: DW]), WB'(exp));
   endtask

   // Drive one accepted pixel and, for interior positions, queue the window built from the image model.
   task automatic pix(input bit sof, input logic [DW-1:0] salt);
      exp_t          e;
      logic [DW-1:0] p;
      @(negedge clk);
      if (sof) begin
         mr = 0;
         mc = 0;
      end
      p = DW'(mr * 16 + mc) + salt;
      bus.in_pixel = p;
      bus.in_valid = 1'b1;
      bus.in_sof   = sof;
      img[mr][mc]  = p;
      if (mr >= 6 && mc >= 6) begin
         e.w = '0;
         for (int r = 1; r <= WIN; r++) begin
            for (int c = 1; c <= WIN; c++) begin
               e.w[win_off(r, c, DW) +: DW] = img[mr - WIN + r][mc - WIN + c];
            end
         end
         e.cr = 3'(mr - 3);
         e.cc = 3'(mc - 3);
         q.push_back(e);
         last_win = e.w;
         exp_vld  = 1'b1;
         held     = 1'b1;
      end else begin
         exp_vld = 1'b0;
         held    = 1'b0;
      end
      if (mc == IW - 1) begin
         mc = 0;
         mr = (mr == IH - 1) ? 0 : mr + 1;
      end else begin
         mc++;
      end
   endtask

   task automatic idle1();
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      exp_vld      = 1'b0;
   endtask

   task automatic frame(input bit sof, input bit gaps, input bit spots,
                        input logic [DW-1:0] salt, input int npix);
      nvalid = 0;
      for (int i = 0; i < npix; i++) begin
         int r;
         int c;
         r = i / IW;
         c = i % IW;
         pix(sof && (i == 0), salt);
         if (spots && r == 6 && c == 6) begin
            idle1();
            spot("d11_first", 1, 1, 10'h000 + salt);
            spot("d17_first", 1, 7, 10'h006 + salt);
            spot("d44_first", 4, 4, 10'h033 + salt);
            spot("d77_first", 7, 7, 10'h066 + salt);
            check("crow_first", WB'(bus.center_row), WB'(3));
            check("ccol_first", WB'(bus.center_col), WB'(3));
            idle1();
            idle1();
         end else if (spots && r == 7 && c == 6) begin
            idle1();
            spot("d77_wrap", 7, 7, 10'h076 + salt);
            spot("d11_wrap", 1, 1, 10'h010 + salt);
         end else if (spots && r == 7 && c == 7) begin
            idle1();
            spot("d77_last", 7, 7, 10'h077 + salt);
            check("crow_last", WB'(bus.center_row), WB'(4));
            check("ccol_last", WB'(bus.center_col), WB'(4));
         end else if (gaps && $urandom_range(0, 3) == 0) begin
            idle1();
         end
      end
      idle1();
      if (npix == IW * IH) begin
         check("frame_windows", WB'(nvalid), WB'((IW - 6) * (IH - 6)));
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         check("win_valid", WB'(bus.win_valid), WB'(exp_vld));
         if (bus.win_valid) begin
            if (q.size() == 0) begin
               check("window_queue", WB'(q.size()), WB'(1));
            end else begin
               mon_e = q.pop_front();
               nvalid++;
               check("win", bus.win, mon_e.w);
               check("center_row", WB'(bus.center_row), WB'(mon_e.cr));
               check("center_col", WB'(bus.center_col), WB'(mon_e.cc));
            end
         end else if (held) begin
            check("hold", bus.win, last_win);
         end
      end
   end

   initial begin
      bus.in_pixel = '0;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      #12;
      check("rst_win", bus.win, '0);
      check("rst_vld", WB'(bus.win_valid), WB'(0));
      check("rst_crow", WB'(bus.center_row), WB'(0));
      check("rst_ccol", WB'(bus.center_col), WB'(0));
      @(negedge clk);
      rst_n = 1'b1;

      frame(1'b1, 1'b0, 1'b0, 10'h000, IW * IH);
      frame(1'b1, 1'b1, 1'b1, 10'h000, IW * IH);

      // Resync: sof arrives where the counters sit at (5,3).
      frame(1'b1, 1'b0, 1'b0, 10'h000, 5 * IW + 3);
      frame(1'b1, 1'b0, 1'b1, 10'h000, IW * IH);

      // Asynchronous reset in the middle of row 6.
      frame(1'b1, 1'b0, 1'b0, 10'h000, 6 * IW + 3);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("midrst_win", bus.win, '0);
      check("midrst_vld", WB'(bus.win_valid), WB'(0));
      check("midrst_crow", WB'(bus.center_row), WB'(0));
      check("midrst_ccol", WB'(bus.center_col), WB'(0));
      check("midrst_queue", WB'(q.size()), WB'(0));
      mr = 0;
      mc = 0;
      exp_vld = 1'b0;
      held = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      frame(1'b0, 1'b0, 1'b1, 10'h000, IW * IH);

      // Back-to-back frames; the second is salted so stale data would show.
      frame(1'b1, 1'b0, 1'b0, 10'h000, IW * IH);
      frame(1'b1, 1'b1, 1'b1, 10'h100, IW * IH);

      repeat (3) idle1();
      check("queue_empty", WB'(q.size()), WB'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bayer_window_7x7.md
Name: bayer_window_7x7

Overview:
- Streaming window generator placed directly upstream of the green-interpolation stage.
- Accepts one raw Bayer pixel per valid cycle in raster order.
- Buffers six previous image lines and presents a registered 7x7 neighbourhood as a flattened bus, with a window-valid strobe and centre coordinates.
- Emits only fully-interior windows; border pixels are not produced.

Parameters:
- DATA_W, 10, pixel width in bits
- IMG_W, 640, active pixels per line (must be >= 7)
- IMG_H, 480, active lines per frame (must be >= 7)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- in_pixel  in  DATA_W  raw Bayer pixel
- in_valid  in  1  in_pixel accepted this cycle; no backpressure
- in_sof  in  1  qualifies with in_valid; marks pixel (0,0) of a frame
- win  out  49*DATA_W  window; Drc at win[((r-1)*7+(c-1))*DATA_W +: DATA_W], r,c in 1..7
- win_valid  out  1  win holds a complete interior window
- center_row  out  $clog2(IMG_H)  image row of D44
- center_col  out  $clog2(IMG_W)  image column of D44

Behaviour:
- Reset (async assert, sync release): win, win_valid, center_row, center_col, row and col counters all 0. Line-buffer contents are not cleared; gating makes stale contents invisible.
- Accepted pixel (in_valid=1): position (row,col) is taken from the counters, except in_sof=1 forces (0,0) for that pixel.
- Counter update after each accepted pixel:
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - row wraps from IMG_H-1 to 0.
  - in_sof overrides any wrap and resynchronises mid-frame.
- Line buffers: chain of 6 buffers, depth IMG_W, addressed by col, read-before-write in the same cycle.
  - LB0 writes in_pixel.
  - LBk writes LB(k-1)'s read data.
  - LBk read data is the pixel (k+1) rows above, same col.
- Column vector per accepted pixel: row7 = in_pixel, row6 = LB0, ..., row1 = LB5.
- Window shift on acceptance only: columns 1..6 take old columns 2..7, column 7 takes the new vector. D77 = (row,col); D11 = (row-6,col-6).
- Latency: win reflects the accepted pixel one cycle later (registered outputs).
- win_valid: registered; =1 the cycle after acceptance iff row>=6 and col>=6; =0 after any cycle with in_valid=0.
- Stall: when in_valid=0, win, counters and centre coords hold; only win_valid drops.
- Centre coordinates: center_row = row-3 and center_col = col-3, updated together with win. Values are don't-care while win_valid=0 but must be deterministic.
- Line wrap: the first 6 pixels of each line produce win_valid=0, even though the window still contains the previous line's tail.
- Frame: exactly (IMG_W-6)*(IMG_H-6) valid windows per frame.
- Reset mid-frame: all registers clear immediately; the stream restarts from (0,0) at the next accepted pixel regardless of in_sof.
- Simultaneous in_sof and counter wrap: in_sof wins.
- in_sof with in_valid=0 is ignored.

Decomposition:
- Shared package:
  - DATA_W default
  - WIN=7 constant
  - index function mapping (r,c) to a win bit offset, used by this block and by consumers slicing D11..D77
- One sub-module: bayer_line_buffer.
  - Single-clock RAM, depth IMG_W, width DATA_W.
  - Synchronous read-before-write at one address.
  - Enable = in_valid.
  - Instantiated 6 times.

Test Plan (IMG_W=8, IMG_H=8; pixel value = row*16+col):
- Full frame, continuous valid, in_sof on first pixel -> first win_valid the cycle after pixel (6,6). D11=0x00, D17=0x06, D44=0x33, D77=0x66, center=(3,3). Exactly 4 valid windows per frame, last with D77=0x77 and center (4,4).
- Random in_valid gaps (e.g. 3 idle cycles after pixel (6,6)) -> win_valid low during gaps, win held. The set of valid windows matches the continuous case exactly.
- Line wrap: after pixel (6,7), pixels (7,0)..(7,5) -> win_valid=0. Pixel (7,6) -> win_valid=1, D77=0x76, D11=0x10.
- in_sof asserted at what counters consider (5,3) -> position resets to (0,0). No win_valid until the new frame's pixel (6,6), which yields D44=0x33.
- rst_n pulsed low mid-frame at row 6 -> outputs 0 asynchronously. After release, a full frame without in_sof behaves exactly as the first scenario.
- Two back-to-back frames -> second frame's windows are correct. D11 of its first valid window = 0x00 from frame 2, not stale frame-1 data.
